// File: rtl/pc_branch_ctrl.sv
// Program-counter / fetch-control stage: run/halt FSM, writable branch-target LUT and
// saturating retired-instruction counter. Define BRANCH_RELATIVE_EN for PC-relative LUT entries.
module pc_branch_ctrl #(
  parameter int             PCW        = 10,
  parameter int             LUTW       = 3,
  parameter int             CNTW       = 16,
  parameter logic [PCW-1:0] START_ADDR = {PCW{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            branch_en,
  input  logic            branch_bool,
  input  logic [LUTW-1:0] target_idx,
  input  logic            lut_we,
  input  logic [LUTW-1:0] lut_waddr,
  input  logic [PCW-1:0]  lut_wdata,
  output logic [PCW-1:0]  prog_counter,
  output logic            running,
  output logic            done,
  output logic [CNTW-1:0] instr_count
);

  localparam int              DEPTH   = 1 << LUTW;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [PCW-1:0]  lut_q [DEPTH];

  logic [PCW-1:0]  lut_entry_s;
  logic [PCW-1:0]  branch_pc_s;
  logic [PCW-1:0]  pc_inc_s;
  logic [CNTW-1:0] cnt_inc_s;

  // Branch target reads the pre-write LUT contents, so a same-cycle write is not visible yet.
  always_comb begin
    lut_entry_s = lut_q[target_idx];
`ifdef BRANCH_RELATIVE_EN
    branch_pc_s = pc_q + lut_entry_s;
`else
    branch_pc_s = lut_entry_s;
`endif
    pc_inc_s    = pc_q + {{(PCW-1){1'b0}}, 1'b1};
    cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
  end

  // Next-state: halt beats branch beats sequential increment; stall freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          cnt_d   = {CNTW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (stall) begin
          state_d = ST_RUN;
        end else if (halt_req) begin
          state_d = ST_HALT;
          cnt_d   = cnt_inc_s;
        end else if (branch_en && branch_bool) begin
          pc_d    = branch_pc_s;
          cnt_d   = cnt_inc_s;
        end else begin
          pc_d    = pc_inc_s;
          cnt_d   = cnt_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = START_ADDR;
        cnt_d   = {CNTW{1'b0}};
      end
    endcase
  end

  // State, PC, counter and LUT registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= START_ADDR;
      cnt_q   <= {CNTW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        lut_q[i] <= {PCW{1'b0}};
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      if (lut_we) begin
        lut_q[lut_waddr] <= lut_wdata;
      end
    end
  end

  assign prog_counter = pc_q;
  assign instr_count  = cnt_q;
  assign running      = (state_q == ST_RUN);
  assign done         = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios then random stimulus
// compared every cycle against an arithmetic reference model.
module tb_pc_branch_ctrl;

  localparam int PCW   = 10;
  localparam int LUTW  = 3;
  localparam int CNTW  = 6;
  localparam int PCMOD = 1 << PCW;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset, start, stall, halt_req, branch_en, branch_bool, lut_we;
  logic [LUTW-1:0] target_idx, lut_waddr;
  logic [PCW-1:0]  lut_wdata;
  logic [PCW-1:0]  prog_counter;
  logic            running, done;
  logic [CNTW-1:0] instr_count;

  pc_branch_ctrl #(.PCW(PCW), .LUTW(LUTW), .CNTW(CNTW), .START_ADDR(10'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_en(branch_en), .branch_bool(branch_bool), .target_idx(target_idx),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_counter(prog_counter), .running(running), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 = idle, 1 = running, 2 = halted
  int m_mode, m_pc, m_cnt;
  int m_lut [1 << LUTW];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int new_pc, new_cnt, new_mode;
    new_pc = m_pc; new_cnt = m_cnt; new_mode = m_mode;
    if (reset) begin
      new_mode = 0; new_pc = 0; new_cnt = 0;
      for (int i = 0; i < (1 << LUTW); i++) m_lut[i] = 0;
    end else begin
      if (m_mode != 1 && start) begin
        new_mode = 1; new_pc = 0; new_cnt = 0;
      end else if (m_mode == 1 && !stall) begin
        new_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
        if (halt_req) new_mode = 2;
        else if (branch_en && branch_bool) begin
`ifdef BRANCH_RELATIVE_EN
          new_pc = (m_pc + m_lut[int'(target_idx)]) % PCMOD;
`else
          new_pc = m_lut[int'(target_idx)];
`endif
        end else new_pc = (m_pc + 1) % PCMOD;
      end
      if (lut_we) m_lut[int'(lut_waddr)] = int'(lut_wdata);
    end
    m_pc = new_pc; m_cnt = new_cnt; m_mode = new_mode;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("pc", 32'(prog_counter), 32'(m_pc));
    check_eq("count", 32'(instr_count), 32'(m_cnt));
    check_eq("running", 32'(running), 32'(m_mode == 1));
    check_eq("done", 32'(done), 32'(m_mode == 2));
  endtask

  task automatic quiet();
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_en = 1'b0;
    branch_bool = 1'b0; lut_we = 1'b0; target_idx = 3'd0; lut_waddr = 3'd0; lut_wdata = 10'd0;
  endtask

  initial begin
    m_mode = 0; m_pc = 0; m_cnt = 0;
    for (int i = 0; i < (1 << LUTW); i++) m_lut[i] = 0;
    quiet();

    // Reset, start, five free-running cycles
    reset = 1'b1; tick();
    check_eq("rst_pc", 32'(prog_counter), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    quiet(); start = 1'b1; tick();
    quiet();
    for (int i = 0; i < 5; i++) tick();
    check_eq("s1_pc", 32'(prog_counter), 32'd5);
    check_eq("s1_count", 32'(instr_count), 32'd5);
    check_eq("s1_running", 32'(running), 32'd1);

    // Halt wins over a taken branch at PC 9
    for (int i = 0; i < 4; i++) tick();
    halt_req = 1'b1; branch_en = 1'b1; branch_bool = 1'b1; target_idx = 3'd2; tick();
    check_eq("s4_pc", 32'(prog_counter), 32'd9);
    check_eq("s4_done", 32'(done), 32'd1);
    quiet(); tick(); tick();
    check_eq("halt_hold_pc", 32'(prog_counter), 32'd9);
    start = 1'b1; tick();
    check_eq("restart_pc", 32'(prog_counter), 32'd0);
    check_eq("restart_count", 32'(instr_count), 32'd0);
    check_eq("restart_done", 32'(done), 32'd0);

    // Taken branch through LUT[2] at PC 7
    quiet(); lut_we = 1'b1; lut_waddr = 3'd2;
`ifdef BRANCH_RELATIVE_EN
    lut_wdata = 10'h3FE;
`else
    lut_wdata = 10'h040;
`endif
    tick();
    quiet();
    for (int i = 0; i < 6; i++) tick();
    check_eq("s3_pre_pc", 32'(prog_counter), 32'd7);
    branch_en = 1'b1; branch_bool = 1'b1; target_idx = 3'd2; tick();
`ifdef BRANCH_RELATIVE_EN
    check_eq("s3_pc", 32'(prog_counter), 32'd5);
`else
    check_eq("s3_pc", 32'(prog_counter), 32'h040);
`endif
    quiet(); branch_en = 1'b1; branch_bool = 1'b0; tick();

    // Stall overrides halt for three cycles
    quiet(); stall = 1'b1; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_eq("s5_running", 32'(running), 32'd1);
    stall = 1'b0; tick();
    check_eq("s5_done", 32'(done), 32'd1);

    // PC wrap from 1023 to 0
    quiet(); start = 1'b1; tick();
    quiet(); lut_we = 1'b1; lut_waddr = 3'd3;
`ifdef BRANCH_RELATIVE_EN
    lut_wdata = 10'd1022;
`else
    lut_wdata = 10'd1023;
`endif
    tick();
    quiet(); branch_en = 1'b1; branch_bool = 1'b1; target_idx = 3'd3; tick();
    check_eq("s2_pre_pc", 32'(prog_counter), 32'd1023);
    quiet(); tick();
    check_eq("s2_wrap_pc", 32'(prog_counter), 32'd0);

    // Same-cycle write and branch to index 1 uses the old entry
    quiet(); lut_we = 1'b1; lut_waddr = 3'd1; lut_wdata = 10'h020; tick();
    lut_wdata = 10'h100; branch_en = 1'b1; branch_bool = 1'b1; target_idx = 3'd1; tick();
    quiet(); branch_en = 1'b1; branch_bool = 1'b1; target_idx = 3'd1; tick();
    quiet(); reset = 1'b1; tick();
    check_eq("s6_reset_pc", 32'(prog_counter), 32'd0);
    check_eq("s6_reset_running", 32'(running), 32'd0);

    // Counter saturation
    quiet(); start = 1'b1; tick();
    quiet();
    for (int i = 0; i < CMAX + 8; i++) tick();
    check_eq("sat_count", 32'(instr_count), 32'(CMAX));

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      reset       = ($urandom_range(199) < 1);
      start       = ($urandom_range(99) < 8);
      stall       = ($urandom_range(99) < 20);
      halt_req    = ($urandom_range(99) < 3);
      branch_en   = ($urandom_range(99) < 35);
      branch_bool = ($urandom_range(99) < 60);
      target_idx  = 3'($urandom_range(7));
      lut_we      = ($urandom_range(99) < 20);
      lut_waddr   = 3'($urandom_range(7));
      lut_wdata   = 10'($urandom_range(1023));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
